// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX definitions: FSM states, CRC-32 constants and frame sizes.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } eth_state_e;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam int ETH_MIN_FRAME_LEN = 60;
  localparam int ETH_FCS_LEN       = 4;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32 (shared by TX and RX FCS logic).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  always_comb begin
    crc_work = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC32_POLY) : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/eth_fcs_pad_tx.sv
// Ethernet TX stage: pads short frames with zeros, appends the CRC-32 FCS, one registered output stage.
// Optional inter-frame gap enabled by defining ETH_FCS_PAD_TX_IFG_EN.
module eth_fcs_pad_tx
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LEN  = ETH_MIN_FRAME_LEN,
  parameter int ENABLE_PADDING = 1
`ifdef ETH_FCS_PAD_TX_IFG_EN
  ,
  parameter int IFG_CYCLES     = 12
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy
);

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
  localparam logic [1:0]  FCS_LAST = 2'(ETH_FCS_LEN - 1);
  localparam bit          PAD_EN   = (ENABLE_PADDING != 0);
`ifdef ETH_FCS_PAD_TX_IFG_EN
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
`endif

  eth_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic        tuser_q, tuser_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tuser_q, m_tuser_d;
`ifdef ETH_FCS_PAD_TX_IFG_EN
  logic [15:0] ifg_cnt_q, ifg_cnt_d;
`endif

  logic        out_free;
  logic        in_fire;
  logic [15:0] cnt_inc;
  logic [7:0]  crc_data;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  eth_state_e  data_end_state;

  assign out_free      = !m_tvalid_q || m_axis_tready;
  assign s_axis_tready = rst_n && out_free && (state_q == IDLE || state_q == PAYLOAD);
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  // Saturating length counter; only the comparison against MIN_LEN matters.
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign crc_data = (state_q == PAD) ? 8'h00 : s_axis_tdata;
  assign fcs_word = ~crc_q;
  assign fcs_byte = fcs_word[{fcs_idx_q, 3'b000} +: 8];

  assign data_end_state = (PAD_EN && (cnt_inc < MIN_LEN)) ? PAD : FCS;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    fcs_idx_d  = fcs_idx_q;
    tuser_d    = tuser_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
`ifdef ETH_FCS_PAD_TX_IFG_EN
    ifg_cnt_d  = ifg_cnt_q;
`endif

    // A transferred or empty output register drains unless reloaded below.
    if (out_free) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
      m_tuser_d  = 1'b0;
    end

    case (state_q)
      IDLE, PAYLOAD: begin
        if (in_fire) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_axis_tdata;
          crc_d      = crc_next;
          cnt_d      = cnt_inc;
          if (s_axis_tlast) begin
            tuser_d   = s_axis_tuser;
            fcs_idx_d = 2'd0;
            state_d   = data_end_state;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAD: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = 8'h00;
          crc_d      = crc_next;
          cnt_d      = cnt_inc;
          if (cnt_inc >= MIN_LEN) begin
            fcs_idx_d = 2'd0;
            state_d   = FCS;
          end
        end
      end

      FCS: begin
`ifdef ETH_FCS_PAD_TX_IFG_EN
        // Last FCS byte already loaded: the gap starts once it is handed over.
        if (m_tvalid_q && m_tlast_q) begin
          if (m_axis_tready) begin
            ifg_cnt_d = 16'd0;
            state_d   = IFG;
          end
        end else if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = fcs_byte;
          m_tlast_d  = (fcs_idx_q == FCS_LAST);
          m_tuser_d  = (fcs_idx_q == FCS_LAST) && tuser_q;
          fcs_idx_d  = fcs_idx_q + 2'd1;
        end
`else
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = fcs_byte;
          m_tlast_d  = (fcs_idx_q == FCS_LAST);
          m_tuser_d  = (fcs_idx_q == FCS_LAST) && tuser_q;
          fcs_idx_d  = fcs_idx_q + 2'd1;
          if (fcs_idx_q == FCS_LAST) begin
            state_d = IDLE;
          end
        end
`endif
      end

`ifdef ETH_FCS_PAD_TX_IFG_EN
      IFG: begin
        if (ifg_cnt_q == IFG_LAST) begin
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 16'd1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // Every return to IDLE starts the next frame from a clean CRC and length.
    if (state_d == IDLE && state_q != IDLE) begin
      crc_d = CRC32_INIT;
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_q      <= CRC32_INIT;
      cnt_q      <= 16'd0;
      fcs_idx_q  <= 2'd0;
      tuser_q    <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
`ifdef ETH_FCS_PAD_TX_IFG_EN
      ifg_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      tuser_q    <= tuser_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
`ifdef ETH_FCS_PAD_TX_IFG_EN
      ifg_cnt_q  <= ifg_cnt_d;
`endif
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign busy          = (state_q != IDLE);

endmodule
